// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light sequencer: state encodings, lamp
// patterns and request bit positions, reused by software-visible status blocks.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FAULT  = 2'd3
    } tl_state_e;

    localparam int REQ_RED_BIT    = 0;
    localparam int REQ_YELLOW_BIT = 1;
    localparam int REQ_GREEN_BIT  = 2;

    // Requests use the same one-hot bit mapping as the lamp outputs.
    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_RED    = 3'(1 << REQ_RED_BIT);
    localparam logic [2:0] LAMP_YELLOW = 3'(1 << REQ_YELLOW_BIT);
    localparam logic [2:0] LAMP_GREEN  = 3'(1 << REQ_GREEN_BIT);

    function automatic logic req_is_invalid(input logic [2:0] r);
        return (r[REQ_RED_BIT]    & r[REQ_YELLOW_BIT]) |
               (r[REQ_RED_BIT]    & r[REQ_GREEN_BIT])  |
               (r[REQ_YELLOW_BIT] & r[REQ_GREEN_BIT]);
    endfunction

endpackage

// File: rtl/traffic_light_blinker.sv
// Fault-aspect blink generator: half-period counter plus toggle flop, restarted
// (blink on, counter cleared) on fault entry and frozen while disabled.
module traffic_light_blinker #(
    parameter int HALF_CYC = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic blink_next_o
);

    localparam int CW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (clear_i) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // Exposed pre-register so the lamp register sees the same edge's value.
    assign blink_next_o = blink_d;

endmodule

// File: rtl/traffic_light_sequencer.sv
// Safety sequencer between the lamp-request PIO and the physical lamps.
// Optional fault-entry counter port enabled by defining TL_SEQ_FAULT_COUNT_EN.
module traffic_light_sequencer
    import traffic_light_pkg::*;
#(
    parameter int MIN_DWELL_CYC  = 50_000_000,
    parameter int YELLOW_CYC     = 150_000_000,
    parameter int BLINK_HALF_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] lamp,
    output logic [1:0] state,
    output logic       fault
`ifdef TL_SEQ_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int CNT_MAX = ((MIN_DWELL_CYC > YELLOW_CYC) ? MIN_DWELL_CYC : YELLOW_CYC) - 1;
    localparam int DW      = $clog2(CNT_MAX) + 1;
    localparam logic [DW-1:0] DWELL_LAST  = DW'(MIN_DWELL_CYC - 1);
    localparam logic [DW-1:0] YELLOW_LAST = DW'(YELLOW_CYC - 1);
    localparam logic [DW-1:0] CNT_SAT     = DW'(CNT_MAX);

    tl_state_e     state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    lamp_q, lamp_d;
    logic          fault_q;
    logic          dwell_ok;
    logic          fault_entry;
    logic          blink_next;

    assign dwell_ok    = (dwell_q >= DWELL_LAST);
    assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

    // Malformed requests pre-empt every other transition, including the yellow timer.
    always_comb begin
        state_d = state_q;
        if (req_is_invalid(req)) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_RED:    if (req == LAMP_GREEN && dwell_ok) state_d = ST_GREEN;
                ST_GREEN:  if ((req == LAMP_YELLOW || req == LAMP_RED) && dwell_ok) state_d = ST_YELLOW;
                ST_YELLOW: if (dwell_q == YELLOW_LAST) state_d = ST_RED;
                ST_FAULT:  if (req == LAMP_RED) state_d = ST_RED;
                default:   state_d = ST_RED;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != CNT_SAT) begin
            dwell_d = dwell_q + 1'b1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    always_comb begin
        unique case (state_d)
            ST_RED:    lamp_d = LAMP_RED;
            ST_GREEN:  lamp_d = LAMP_GREEN;
            ST_YELLOW: lamp_d = LAMP_YELLOW;
            ST_FAULT:  lamp_d = blink_next ? LAMP_YELLOW : LAMP_OFF;
            default:   lamp_d = LAMP_RED;
        endcase
    end

    traffic_light_blinker #(
        .HALF_CYC (BLINK_HALF_CYC)
    ) u_blinker (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (fault_entry),
        .en_i         (state_q == ST_FAULT),
        .blink_next_o (blink_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RED;
            dwell_q <= '0;
            lamp_q  <= LAMP_RED;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            lamp_q  <= lamp_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign lamp  = lamp_q;
    assign state = state_q;
    assign fault = fault_q;

`ifdef TL_SEQ_FAULT_COUNT_EN
    logic [7:0] fault_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_cnt_q <= '0;
        end else if (fault_entry && fault_cnt_q != 8'hFF) begin
            fault_cnt_q <= fault_cnt_q + 1'b1;
        end
    end

    assign fault_count = fault_cnt_q;
`endif

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench for traffic_light_sequencer: directed scenarios plus
// randomized requests against a time-since-entry behavioural model.
module tb_traffic_light_sequencer;

    localparam int MIN  = 4;
    localparam int YEL  = 3;
    localparam int HALF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] lamp;
    logic [1:0] state;
    logic       fault;
`ifdef TL_SEQ_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: current aspect (0 red, 1 green, 2 yellow, 3 fault), edges since
    // entering it, and number of fault entries (saturating).
    int m_state = 0;
    int m_t     = 0;
    int m_fc    = 0;

    traffic_light_sequencer #(
        .MIN_DWELL_CYC  (MIN),
        .YELLOW_CYC     (YEL),
        .BLINK_HALF_CYC (HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lamp        (lamp),
        .state       (state),
        .fault       (fault)
`ifdef TL_SEQ_FAULT_COUNT_EN
        ,
        .fault_count (fault_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int  nxt;
        bit  ok;
        if (reset) begin
            m_state = 0;
            m_t     = 0;
            m_fc    = 0;
        end else begin
            ok  = (m_t >= MIN - 1);
            nxt = m_state;
            if ($countones(req) >= 2) nxt = 3;
            else begin
                case (m_state)
                    0:       if (req == 3'b100 && ok) nxt = 1;
                    1:       if ((req == 3'b010 || req == 3'b001) && ok) nxt = 2;
                    2:       if (m_t + 1 == YEL) nxt = 0;
                    default: if (req == 3'b001) nxt = 0;
                endcase
            end
            if (nxt != m_state) begin
                if (nxt == 3 && m_fc < 255) m_fc++;
                m_state = nxt;
                m_t     = 0;
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [2:0] el;
        if (chk_en) begin
            case (m_state)
                0:       el = 3'b001;
                1:       el = 3'b100;
                2:       el = 3'b010;
                default: el = (((m_t / HALF) % 2) == 0) ? 3'b010 : 3'b000;
            endcase
            check("model_lamp", lamp, el);
            check("model_state", state, m_state[1:0]);
            check("model_fault", fault, (m_state == 3) ? 1 : 0);
`ifdef TL_SEQ_FAULT_COUNT_EN
            check("model_fault_count", fault_count, m_fc);
`endif
        end
    end

    task automatic cyc(input logic [2:0] r, input int n);
        req = r;
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] inv_pool [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        int         sel;
        int         len;
        logic [2:0] r;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_lamp", lamp, 3'b001);
        check("reset_state", state, 2'd0);
        check("reset_fault", fault, 1'b0);

        // Idle requests keep RED.
        reset = 1'b0;
        cyc(3'b000, 10);
        check("idle_lamp", lamp, 3'b001);
        check("idle_state", state, 2'd0);

        // Fresh RED, green request from cycle 0: lamp changes at edge 4.
        reset = 1'b1;
        cyc(3'b000, 1);
        reset = 1'b0;
        cyc(3'b100, 3);
        check("green_not_before_dwell", lamp, 3'b001);
        cyc(3'b100, 1);
        check("green_at_edge4", lamp, 3'b100);
        cyc(3'b001, 3);
        check("green_dwell_hold", lamp, 3'b100);
        cyc(3'b001, 1);
        check("yellow_entry", lamp, 3'b010);
        cyc(3'b001, 2);
        check("yellow_hold", lamp, 3'b010);
        cyc(3'b001, 1);
        check("yellow_to_red", lamp, 3'b001);

        // Short green request is not latched; yellow request ignored in RED.
        cyc(3'b100, 2);
        cyc(3'b000, 6);
        check("short_req_dropped", state, 2'd0);
        cyc(3'b010, 6);
        check("red_ignores_yellow", state, 2'd0);
        cyc(3'b100, 1);
        check("red_to_green_late", state, 2'd1);

        // Invalid request in GREEN: immediate fault and blink pattern.
        cyc(3'b110, 1);
        check("fault_flag", fault, 1'b1);
        check("fault_state", state, 2'd3);
        check("blink_0", lamp, 3'b010);
        cyc(3'b000, 1);
        check("blink_1", lamp, 3'b010);
        cyc(3'b000, 1);
        check("blink_2", lamp, 3'b000);
        cyc(3'b000, 1);
        check("blink_3", lamp, 3'b000);
        cyc(3'b000, 1);
        check("blink_4", lamp, 3'b010);
        cyc(3'b001, 1);
        check("fault_exit", state, 2'd0);
        check("fault_exit_lamp", lamp, 3'b001);

        // YELLOW ignores valid requests and exits on schedule.
        cyc(3'b100, 4);
        cyc(3'b000, 3);
        cyc(3'b010, 1);
        check("yellow_via_010", state, 2'd2);
        cyc(3'b100, 2);
        check("yellow_ignores_green", lamp, 3'b010);
        cyc(3'b100, 1);
        check("yellow_on_schedule", state, 2'd0);

        // Invalid request in YELLOW pre-empts the timer.
        cyc(3'b100, 4);
        cyc(3'b000, 3);
        cyc(3'b001, 1);
        check("yellow_again", state, 2'd2);
        cyc(3'b011, 1);
        check("yellow_to_fault", state, 2'd3);
        cyc(3'b001, 1);
        check("fault_to_red", state, 2'd0);

        // Randomized requests with occasional resets.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 15);
            len = $urandom_range(1, 6);
            if (sel < 4)       r = 3'b000;
            else if (sel < 8)  r = 3'b100;
            else if (sel < 11) r = 3'b001;
            else if (sel < 13) r = 3'b010;
            else if (sel < 14) r = inv_pool[$urandom_range(0, 3)];
            else               r = req;
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                cyc(r, 1);
                reset = 1'b0;
            end
            cyc(r, len);
        end

`ifdef TL_SEQ_FAULT_COUNT_EN
        reset = 1'b1;
        cyc(3'b000, 1);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(3'b111, 1);
            cyc(3'b001, 1);
        end
        check("fault_count_sat", fault_count, 8'd255);
        cyc(3'b100, 4);
        cyc(3'b001, 4);
        cyc(3'b001, 1);
        check("mid_yellow", state, 2'd2);
        reset = 1'b1;
        cyc(3'b001, 1);
        check("reset_mid_yellow_lamp", lamp, 3'b001);
        check("reset_mid_yellow_count", fault_count, 8'd0);
        reset = 1'b0;
        cyc(3'b000, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Hardware safety sequencer sitting directly downstream of the Nios II traffic-light PIO. It consumes the PIO's 3-bit lamp request (`out_port`) and drives the physical lamp outputs, enforcing legal sequencing (green→yellow→red), minimum dwell per aspect and a fixed yellow interval. Malformed requests force a blinking-yellow fault aspect, so software bugs cannot produce illegal or conflicting lamp states.

## Interface
Parameters:
- `MIN_DWELL_CYC`, default 50_000_000: minimum cycles spent in RED or GREEN before a requested change is honoured (≥1).
- `YELLOW_CYC`, default 150_000_000: exact cycles spent in YELLOW (≥1).
- `BLINK_HALF_CYC`, default 25_000_000: half-period of the fault blink (≥1).

Ports:
- `clk` in 1: single clock, same domain as the PIO.
- `reset` in 1: synchronous, active-high reset.
- `req` in 3: lamp request from PIO `out_port`; bit0 red, bit1 yellow, bit2 green.
- `lamp` out 3: lamp drive, same bit mapping as `req`.
- `state` out 2: current state encoding, for software readback via a separate PIO.
- `fault` out 1: high while in FAULT.
- `fault_count` out 8: present only with `TL_SEQ_FAULT_COUNT_EN`.

## Operation
- States and encodings: RED=0, GREEN=1, YELLOW=2, FAULT=3. Lamps: RED→001, GREEN→100, YELLOW→010, FAULT→{0,blink,0}.
- Request classes: idle (000), valid one-hot (001/010/100), invalid (any value with ≥2 bits set).
- Invalid request, in any state including YELLOW: go to FAULT. This has priority over every other transition.
- RED: `req`=100 and dwell satisfied → GREEN. Otherwise stay (010 is ignored in RED).
- GREEN: `req`=010 or 001 and dwell satisfied → YELLOW. Otherwise stay.
- YELLOW: ignores valid and idle requests. Goes to RED after exactly `YELLOW_CYC` cycles.
- FAULT: `req`=001 → RED. Idle or other valid requests → stay.
- Dwell counter: 0 on the first cycle in a state and increments each cycle. It saturates at max(MIN_DWELL_CYC, YELLOW_CYC)−1. Width is $clog2 of that value + 1.
- Dwell is satisfied when count ≥ `MIN_DWELL_CYC`−1. YELLOW exits when count == `YELLOW_CYC`−1.
- Blink: set to 1 on FAULT entry and toggles every `BLINK_HALF_CYC` cycles using its own counter. The counter is cleared on FAULT entry.
- Reset values: state RED, `lamp`=001, `fault`=0, dwell and blink counters 0, blink=1, `fault_count`=0.
- Reset asserted mid-sequence, including YELLOW or FAULT, returns to RED on the next edge.

## Timing
- `req` is sampled combinationally into the next-state logic. `state`, `lamp` and `fault` are registered, so a qualifying `req` at edge N produces the new lamp at edge N+1.
- Every state lasts at least 1 cycle. RED and GREEN last at least `MIN_DWELL_CYC` cycles. YELLOW lasts exactly `YELLOW_CYC` cycles.
- `lamp` is always one of 001, 010, 100 or 000 (FAULT blink-off). It never has two bits set.
- A request change that arrives while dwell is unsatisfied is not latched. It takes effect only if it is still present when dwell becomes satisfied.

## Configuration
- `TL_SEQ_FAULT_COUNT_EN` defined: adds the `fault_count` port.
  - 8-bit counter, +1 on each entry into FAULT (not per cycle spent in FAULT).
  - Saturates at 255.
  - Cleared only by `reset`.
- Macro undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `traffic_light_pkg`: state enum/encodings, lamp constants `LAMP_RED`, `LAMP_YELLOW`, `LAMP_GREEN`, `LAMP_OFF`, and the request bit indices. Future software-visible status blocks reuse it.
- One sub-module, `traffic_light_blinker`: enable-gated half-period counter plus toggle flop. Cleared synchronously on FAULT entry and held while not in FAULT.
- The main module contains the FSM, dwell counter and optional fault counter.

## Test plan
Bench parameters: `MIN_DWELL_CYC`=4, `YELLOW_CYC`=3, `BLINK_HALF_CYC`=2.
- Reset, `req`=000 held for 10 cycles → `lamp`=001, `state`=0, `fault`=0 throughout.
- From reset, `req`=100 from cycle 0 → `lamp`=100 at edge 4. Then `req`=001 → `lamp`=010 after 4 GREEN cycles, then `lamp`=001 exactly 3 cycles later.
- In RED, `req`=100 for only 2 cycles, then 000 → no transition. In RED, `req`=010 → stays RED.
- In GREEN, `req`=110 → next edge: `fault`=1, `state`=3, `lamp` pattern 010,010,000,000,010…. Then `req`=001 → RED on the next edge.
- In YELLOW, `req`=100 → ignored, RED reached on schedule. In YELLOW, `req`=011 → FAULT immediately.
- With `TL_SEQ_FAULT_COUNT_EN`: 300 fault entries → `fault_count`=255. Assert `reset` mid-YELLOW → next edge `lamp`=001, `fault_count`=0.
